// File: rtl/rv16_mul_issue.sv
// rv16_mul_issue
// Issues a MUL instruction from the execute stage to the shared ALU multiply
// unit. It waits for the unit to finish, then writes the result back. It
// handles pipeline flushes, a bounded wait with a sticky timeout flag, and an
// asynchronous reset.
//
// Parameters
//   TIMEOUT       maximum number of WAIT cycles without done (1..255)
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   i_valid       execute stage presents a MUL instruction
//   i_operand_a/b source operands (32 bits each)
//   i_rd          destination register index
//   i_flush       cancel the presented or in-flight instruction
//   i_mul_busy    multiply unit status: busy
//   i_mul_done    multiply unit status: done
//   i_mul_result  multiply unit result bus
//   o_ready       block can accept a new instruction (IDLE only)
//   o_stall       hold the upstream pipeline
//   o_mul_start   level start to the multiply unit (the unit edge-detects it)
//   o_operand_a/b latched operands to the multiply unit
//   o_alu_op      ALU opcode (MUL while an operation is active)
//   o_wb_valid    one-cycle writeback strobe
//   o_wb_rd       writeback destination index
//   o_wb_data     writeback data
//   o_timeout     sticky error flag, cleared only by reset
module rv16_mul_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_operand_a,
    input  logic [31:0] i_operand_b,
    input  logic [3:0]  i_rd,
    input  logic        i_flush,
    input  logic        i_mul_busy,
    input  logic        i_mul_done,
    input  logic [31:0] i_mul_result,
    output logic        o_ready,
    output logic        o_stall,
    output logic        o_mul_start,
    output logic [31:0] o_operand_a,
    output logic [31:0] o_operand_b,
    output logic [3:0]  o_alu_op,
    output logic        o_wb_valid,
    output logic [3:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        DRAIN
    } state_t;

    localparam logic [3:0] ALU_OP_MUL  = 4'b1010;
    localparam logic [3:0] ALU_OP_NONE = 4'b0000;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  count_q, count_nxt;
    logic [31:0] op_a_q, op_b_q, result_q;
    logic [3:0]  rd_q;
    logic        timeout_q;
    logic        accept, capture, timeout_set;

    // State register and datapath latches. The operands and rd change only
    // when an instruction is accepted. The result changes only when done is
    // taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_q   <= 8'd0;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            rd_q      <= 4'd0;
            result_q  <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
            if (accept) begin
                op_a_q <= i_operand_a;
                op_b_q <= i_operand_b;
                rd_q   <= i_rd;
            end
            if (capture) begin
                result_q <= i_mul_result;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state logic.
    // ISSUE treats a done exactly as WAIT does, so a unit that finishes in
    // one cycle is not missed. Flush wins over done. When flush and done
    // arrive together, the unit is already idle, so the block returns to IDLE
    // directly instead of going through DRAIN. In WAIT, done wins over the
    // timeout. The timeout fires on the WAIT cycle whose incremented count
    // reaches TIMEOUT. That is after TIMEOUT full WAIT cycles without done.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count_q;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (state == ISSUE) begin
                    count_nxt = 8'd0;
                end
                if (i_flush && i_mul_done) begin
                    state_nxt = IDLE;
                end else if (i_flush) begin
                    state_nxt = DRAIN;
                end else if (i_mul_done) begin
                    capture   = 1'b1;
                    state_nxt = WB;
                end else if (state == ISSUE) begin
                    state_nxt = WAIT;
                end else if (count_q + 8'd1 == TIMEOUT_CNT) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    count_nxt = count_q + 8'd1;
                end
            end
            WB: begin
                state_nxt = IDLE;
            end
            DRAIN: begin
                if (i_mul_done || !i_mul_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Start is low in WB, DRAIN and IDLE. Back-to-back operations therefore
    // always show the multiply unit a fresh rising edge. The stall term that
    // depends on the inputs is gated by rst, so reset drives stall low even
    // while i_valid is high.
    assign o_ready     = (state == IDLE);
    assign o_stall     = !rst && ((state == IDLE && i_valid && !i_flush) ||
                                  state == ISSUE || state == WAIT || state == DRAIN);
    assign o_mul_start = (state == ISSUE) || (state == WAIT);
    assign o_alu_op    = (state == ISSUE || state == WAIT || state == WB) ? ALU_OP_MUL : ALU_OP_NONE;
    assign o_operand_a = op_a_q;
    assign o_operand_b = op_b_q;
    assign o_wb_valid  = (state == WB) && !i_flush;
    assign o_wb_rd     = rd_q;
    assign o_wb_data   = result_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_rv16_mul_issue.sv
// tb_rv16_mul_issue
// Self-checking bench for rv16_mul_issue, built with TIMEOUT=4.
// The bench drives inputs 1 ns after each rising edge and samples outputs on
// the falling edge. For every instruction that should write back, it pushes
// the expected rd and product to a queue. A monitor pops the queue on each
// writeback strobe. A strobe that arrives when the queue is empty is an error.
module tb_rv16_mul_issue;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic [3:0]  i_rd;
    logic        i_flush;
    logic        i_mul_busy;
    logic        i_mul_done;
    logic [31:0] i_mul_result;
    logic        o_ready;
    logic        o_stall;
    logic        o_mul_start;
    logic [31:0] o_operand_a;
    logic [31:0] o_operand_b;
    logic [3:0]  o_alu_op;
    logic        o_wb_valid;
    logic [3:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_timeout;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;

    rv16_mul_issue #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_operand_a  (i_operand_a),
        .i_operand_b  (i_operand_b),
        .i_rd         (i_rd),
        .i_flush      (i_flush),
        .i_mul_busy   (i_mul_busy),
        .i_mul_done   (i_mul_done),
        .i_mul_result (i_mul_result),
        .o_ready      (o_ready),
        .o_stall      (o_stall),
        .o_mul_start  (o_mul_start),
        .o_operand_a  (o_operand_a),
        .o_operand_b  (o_operand_b),
        .o_alu_op     (o_alu_op),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_timeout    (o_timeout)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge. Returns at the
    // falling edge, where the caller samples the outputs.
    task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] rd, input logic flush, input logic busy,
                                 input logic done, input logic [31:0] result);
        @(posedge clk);
        #1;
        i_valid      = valid;
        i_operand_a  = a;
        i_operand_b  = b;
        i_rd         = rd;
        i_flush      = flush;
        i_mul_busy   = busy;
        i_mul_done   = done;
        i_mul_result = result;
        @(negedge clk);
    endtask

    task automatic pushExpected(input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
        wb_exp_t e;
        e.rd   = rd;
        e.data = a * b;
        sb.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    // Writeback monitor. It compares each strobe against the oldest expected
    // entry.
    always @(negedge clk) begin
        if (!rst && o_wb_valid) begin
            if (sb.size() == 0) begin
                checkOutput("wb_unexpected", 64'd1, 64'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                checkOutput("wb_rd", 64'(o_wb_rd), 64'(e.rd));
                checkOutput("wb_data", 64'(o_wb_data), 64'(e.data));
            end
        end
    end

    // Watchdog. The scenarios are fixed-length, so hitting this means the
    // simulation itself is stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_ready"},  64'(o_ready), 64'd1);
        checkOutput({pfx, "_stall"},  64'(o_stall), 64'd0);
        checkOutput({pfx, "_start"},  64'(o_mul_start), 64'd0);
        checkOutput({pfx, "_opa"},    64'(o_operand_a), 64'd0);
        checkOutput({pfx, "_opb"},    64'(o_operand_b), 64'd0);
        checkOutput({pfx, "_aluop"},  64'(o_alu_op), 64'd0);
        checkOutput({pfx, "_wbv"},    64'(o_wb_valid), 64'd0);
        checkOutput({pfx, "_wbrd"},   64'(o_wb_rd), 64'd0);
        checkOutput({pfx, "_wbdata"}, 64'(o_wb_data), 64'd0);
        checkOutput({pfx, "_tmo"},    64'(o_timeout), 64'd0);
    endtask

    initial begin
        // Hold reset with i_valid high. Stall must still read 0.
        rst          = 1'b1;
        i_valid      = 1'b1;
        i_operand_a  = 32'hDEAD_BEEF;
        i_operand_b  = 32'h1234_5678;
        i_rd         = 4'hF;
        i_flush      = 1'b0;
        i_mul_busy   = 1'b0;
        i_mul_done   = 1'b0;
        i_mul_result = 32'd0;
        #7;
        checkResetOutputs("rst0");
        #4;
        i_valid = 1'b0;
        rst     = 1'b0;

        // Basic 7*6: done arrives on the third WAIT cycle.
        applyStimulus(1'b1, 32'd7, 32'd6, 4'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExpected(4'd5, 32'd7, 32'd6);
        checkOutput("s1_idle_ready", 64'(o_ready), 64'd1);
        checkOutput("s1_idle_stall", 64'(o_stall), 64'd1);
        checkOutput("s1_idle_start", 64'(o_mul_start), 64'd0);
        busyCycle();
        checkOutput("s1_issue_start", 64'(o_mul_start), 64'd1);
        checkOutput("s1_issue_aluop", 64'(o_alu_op), 64'hA);
        checkOutput("s1_issue_opa", 64'(o_operand_a), 64'd7);
        checkOutput("s1_issue_opb", 64'(o_operand_b), 64'd6);
        checkOutput("s1_issue_ready", 64'(o_ready), 64'd0);
        busyCycle();
        checkOutput("s1_w1_start", 64'(o_mul_start), 64'd1);
        busyCycle();
        checkOutput("s1_w2_start", 64'(o_mul_start), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd42);
        checkOutput("s1_w3_start", 64'(o_mul_start), 64'd1);
        checkOutput("s1_w3_stall", 64'(o_stall), 64'd1);
        idleCycle();
        checkOutput("s1_wb_valid", 64'(o_wb_valid), 64'd1);
        checkOutput("s1_wb_start", 64'(o_mul_start), 64'd0);
        checkOutput("s1_wb_aluop", 64'(o_alu_op), 64'hA);
        checkOutput("s1_wb_stall", 64'(o_stall), 64'd0);
        idleCycle();
        checkOutput("s1_end_ready", 64'(o_ready), 64'd1);
        checkOutput("s1_end_wbv", 64'(o_wb_valid), 64'd0);
        checkOutput("s1_end_aluop", 64'(o_alu_op), 64'd0);

        // i_valid held across two instructions: 3*4, then 5*5.
        applyStimulus(1'b1, 32'd3, 32'd4, 4'd1, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExpected(4'd1, 32'd3, 32'd4);
        applyStimulus(1'b1, 32'd3, 32'd4, 4'd1, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("s2_issue_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b1, 32'd3, 32'd4, 4'd1, 1'b0, 1'b1, 1'b1, 32'd12);
        applyStimulus(1'b1, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("s2_wb_start", 64'(o_mul_start), 64'd0);
        checkOutput("s2_wb_ready", 64'(o_ready), 64'd0);
        checkOutput("s2_wb_opa", 64'(o_operand_a), 64'd3);
        applyStimulus(1'b1, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExpected(4'd2, 32'd5, 32'd5);
        checkOutput("s2_gap_start", 64'(o_mul_start), 64'd0);
        checkOutput("s2_gap_ready", 64'(o_ready), 64'd1);
        busyCycle();
        checkOutput("s2_issue2_start", 64'(o_mul_start), 64'd1);
        checkOutput("s2_issue2_opa", 64'(o_operand_a), 64'd5);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd25);
        idleCycle();
        checkOutput("s2_wb2_valid", 64'(o_wb_valid), 64'd1);
        idleCycle();

        // Flush on the first WAIT cycle. Done arrives two cycles later,
        // during DRAIN.
        applyStimulus(1'b1, 32'd9, 32'd9, 4'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        busyCycle();
        checkOutput("s3_drain_start", 64'(o_mul_start), 64'd0);
        checkOutput("s3_drain_stall", 64'(o_stall), 64'd1);
        checkOutput("s3_drain_ready", 64'(o_ready), 64'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd81);
        checkOutput("s3_done_ready", 64'(o_ready), 64'd0);
        idleCycle();
        checkOutput("s3_after_ready", 64'(o_ready), 64'd1);

        // Done and flush in the same WAIT cycle.
        applyStimulus(1'b1, 32'd8, 32'd8, 4'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b1, 32'd64);
        idleCycle();
        checkOutput("s4_ready", 64'(o_ready), 64'd1);
        checkOutput("s4_wbv", 64'(o_wb_valid), 64'd0);

        // Flush during WB suppresses the strobe. Flush in IDLE blocks
        // acceptance.
        applyStimulus(1'b1, 32'd6, 32'd7, 4'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd42);
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("s5_wbflush_wbv", 64'(o_wb_valid), 64'd0);
        applyStimulus(1'b1, 32'd2, 32'd2, 4'd2, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("s5_idleflush_stall", 64'(o_stall), 64'd0);
        idleCycle();
        checkOutput("s5_idleflush_ready", 64'(o_ready), 64'd1);
        checkOutput("s5_idleflush_start", 64'(o_mul_start), 64'd0);

        // Done on the fourth WAIT cycle wins over the timeout.
        applyStimulus(1'b1, 32'd2, 32'd8, 4'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExpected(4'd7, 32'd2, 32'd8);
        busyCycle();
        for (int i = 0; i < 3; i++) busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd16);
        checkOutput("s6_w4_start", 64'(o_mul_start), 64'd1);
        idleCycle();
        checkOutput("s6_wb_valid", 64'(o_wb_valid), 64'd1);
        checkOutput("s6_tmo", 64'(o_timeout), 64'd0);
        idleCycle();

        // Timeout: done never comes. The flag sets after the fourth WAIT
        // cycle and stays set.
        applyStimulus(1'b1, 32'd1, 32'd1, 4'd8, 1'b0, 1'b0, 1'b0, 32'd0);
        busyCycle();
        for (int i = 0; i < 3; i++) busyCycle();
        busyCycle();
        checkOutput("s7_w4_tmo", 64'(o_timeout), 64'd0);
        checkOutput("s7_w4_start", 64'(o_mul_start), 64'd1);
        idleCycle();
        checkOutput("s7_idle_ready", 64'(o_ready), 64'd1);
        checkOutput("s7_idle_tmo", 64'(o_timeout), 64'd1);
        checkOutput("s7_idle_start", 64'(o_mul_start), 64'd0);
        applyStimulus(1'b1, 32'd11, 32'd3, 4'd9, 1'b0, 1'b0, 1'b0, 32'd0);
        pushExpected(4'd9, 32'd11, 32'd3);
        busyCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd33);
        idleCycle();
        idleCycle();
        checkOutput("s7_sticky_tmo", 64'(o_timeout), 64'd1);

        // Reset pulsed during WAIT. The operation is abandoned and no
        // writeback follows.
        applyStimulus(1'b1, 32'd4, 32'd4, 4'd6, 1'b0, 1'b0, 1'b0, 32'd0);
        busyCycle();
        busyCycle();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        i_valid      = 1'b1;
        i_mul_done   = 1'b1;
        i_mul_result = 32'd16;
        #1;
        checkResetOutputs("s8_rst");
        @(posedge clk);
        #2;
        i_valid = 1'b0;
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'd16);
        checkOutput("s8_after_ready", 64'(o_ready), 64'd1);
        checkOutput("s8_after_wbv", 64'(o_wb_valid), 64'd0);
        idleCycle();
        idleCycle();
        checkOutput("s8_after2_ready", 64'(o_ready), 64'd1);
        checkOutput("s8_after2_tmo", 64'(o_timeout), 64'd0);

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv16_mul_issue.md
RV16_MUL_ISSUE -- requirements
Module: rv16_mul_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles (legal range 1..255) before the operation is abandoned.
REQ-002 SHALL have ports clk (input, 1): the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst (input, 1): asynchronous, active-high reset.
REQ-004 SHALL have port i_valid (input, 1): the execute stage presents a MUL instruction.
REQ-005 SHALL have ports i_operand_a and i_operand_b (input, 32 each): source operands.
REQ-006 SHALL have port i_rd (input, 4): destination register index.
REQ-007 SHALL have port i_flush (input, 1): cancel the in-flight or presented instruction.
REQ-008 SHALL have ports i_mul_busy and i_mul_done (input, 1 each): status from the ALU multiply unit.
REQ-009 SHALL have port i_mul_result (input, 32): ALU result bus.
REQ-010 SHALL have port o_ready (output, 1): the block can accept a new instruction.
REQ-011 SHALL have port o_stall (output, 1): hold the upstream pipeline.
REQ-012 SHALL have port o_mul_start (output, 1): level start to the ALU, which edge-detects it.
REQ-013 SHALL have ports o_operand_a and o_operand_b (output, 32 each): latched operands to the ALU.
REQ-014 SHALL have port o_alu_op (output, 4): ALU opcode.
REQ-015 SHALL have ports o_wb_valid (output, 1), o_wb_rd (output, 4) and o_wb_data (output, 32): the writeback strobe, destination index and data.
REQ-016 SHALL have port o_timeout (output, 1): sticky error flag.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT, WB and DRAIN.
REQ-018 IDLE: o_ready=1; when i_valid=1 and i_flush=0, SHALL latch the operands and i_rd, then go to ISSUE.
REQ-019 ISSUE: SHALL drive o_mul_start=1 and go to WAIT unconditionally; if i_mul_done=1 in this cycle, it SHALL be handled exactly as in WAIT.
REQ-020 WAIT: SHALL hold o_mul_start=1; on i_mul_done=1 it SHALL capture i_mul_result and go to WB.
REQ-021 WAIT: an 8-bit counter SHALL clear on entry to WAIT and increment every WAIT cycle without done.
- When count==TIMEOUT: set o_timeout=1 and go to IDLE without writeback.
REQ-022 WB: SHALL assert o_wb_valid for exactly one cycle with o_wb_rd/o_wb_data equal to the latched values, drive o_mul_start=0, then go to IDLE.
REQ-023 SHALL keep o_mul_start low for at least one cycle between consecutive operations, so every operation produces a fresh rising edge.
REQ-024 SHALL drive o_alu_op=4'b1010 in ISSUE, WAIT and WB, and 4'b0000 otherwise.
REQ-025 o_operand_a/b SHALL hold the latched values in all states and change only on acceptance.
REQ-026 o_stall SHALL equal (IDLE and i_valid and not i_flush) or ISSUE or WAIT or DRAIN; it is combinational.
REQ-027 o_ready SHALL be 1 only in IDLE; a held i_valid during busy is not accepted until IDLE.
REQ-028 Flush handling:
- i_flush in ISSUE or WAIT SHALL go to DRAIN with o_mul_start=0.
- DRAIN SHALL go to IDLE on i_mul_done=1 or i_mul_busy=0; no writeback.
REQ-029 Flush in WB SHALL force o_wb_valid=0 that cycle; flush in IDLE SHALL block acceptance.
REQ-030 Simultaneous i_mul_done and i_flush in WAIT SHALL discard the result and go to IDLE.
REQ-031 Simultaneous i_mul_done and count==TIMEOUT SHALL take done; no timeout.
REQ-032 o_timeout SHALL remain 1 until reset.

Reset
REQ-033 While rst=1, SHALL set state=IDLE and counter=0.
REQ-034 While rst=1, all outputs SHALL be: o_ready=1, o_stall=0, o_mul_start=0, o_operand_a/b=0, o_alu_op=0, o_wb_valid=0, o_wb_rd=0, o_wb_data=0, o_timeout=0.
REQ-035 Reset mid-operation SHALL abandon the operation immediately, with no writeback after release.

Verification
REQ-036 A=7, B=6, rd=5, done on the 3rd WAIT cycle with result 42 -> o_mul_start high from ISSUE through the done cycle; o_wb_valid for one cycle with rd=5 and data=42.
REQ-037 i_valid held for two instructions (A=3,B=4 then A=5,B=5) -> second accepted only in the IDLE after WB; o_mul_start low for ≥1 cycle between; writebacks 12 then 25.
REQ-038 i_flush on the 1st WAIT cycle, done 2 cycles later -> DRAIN, o_wb_valid never asserted, o_ready=1 the cycle after done.
REQ-039 TIMEOUT=4, done never asserted -> o_timeout=1 after the 4th WAIT cycle, return to IDLE, no writeback, flag sticky.
REQ-040 rst pulsed during WAIT -> all outputs at reset values immediately; no o_wb_valid after release.
REQ-041 done and i_flush in the same WAIT cycle -> no writeback, IDLE next cycle.
